// File: rtl/spi_cfg_pkg.sv
// Shared definitions for spi_config_regs: frame FSM states, command field layout
// and the register slice offset helper.
package spi_cfg_pkg;

  typedef enum logic [1:0] {CMD, WR, RD} frame_state_t;

  // Command is {rw, addr[AW-1:0]}: the R/W flag sits directly above the address field.
  localparam int CMD_ADDR_LSB = 0;

  function automatic int cmd_rw_bit(input int aw);
    return aw;
  endfunction

  function automatic int reg_offset(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/spi_miso_drv.sv
// Falling-edge MISO output flop; held at 0 while chip select is inactive or in reset.
module spi_miso_drv (
  input  logic spi_clk,
  input  logic rst,
  input  logic spi_csn,
  input  logic d,
  output logic q
);

  always_ff @(negedge spi_clk or posedge rst or posedge spi_csn) begin
    if (rst || spi_csn) q <= 1'b0;
    else                q <= d;
  end

endmodule

// File: rtl/spi_config_regs.sv
// Addressed SPI (mode 0) register file with auto-increment bursts and word-atomic commits.
// Optional `SPI_CFG_WSTROBE_EN adds a one-cycle write strobe with the committed address.
module spi_config_regs
  import spi_cfg_pkg::*;
#(
  parameter int                NREG    = 8,
  parameter int                W       = 8,
  parameter int                AW      = 7,
  parameter logic [NREG*W-1:0] RST_VAL = '0,
  parameter logic [NREG-1:0]   RO_MASK = '0
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NREG*W-1:0] cfg,
  output logic              err
`ifdef SPI_CFG_WSTROBE_EN
  ,
  output logic              wr_stb,
  output logic [AW-1:0]     wr_addr
`endif
);

  localparam int SW     = (AW > W - 1) ? AW : W - 1;
  localparam int NBITS  = (AW + 1 > W) ? AW + 1 : W;
  localparam int CW     = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int RW_BIT = cmd_rw_bit(AW);

  frame_state_t  state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [SW-1:0] sh;
  logic [AW-1:0] addr;
  logic [W-1:0]  tx;

  logic [AW:0]   cmd;
  logic [AW-1:0] cmd_addr, acc_addr;
  logic [W-1:0]  word, rd_word;
  logic          last_cmd, word_end, is_write, hit, ro;
  logic          rd_load, wr_commit, wr_ok, wr_drop;

  // Incoming bit completes the field combinationally so commits land on its own edge.
  assign cmd       = {sh[AW-1:0], spi_mosi};
  assign word      = {sh[W-2:0], spi_mosi};
  assign is_write  = cmd[RW_BIT];
  assign cmd_addr  = cmd[AW-1:CMD_ADDR_LSB];
  assign last_cmd  = (bit_cnt == CW'(AW));
  assign word_end  = (bit_cnt == CW'(W - 1));
  assign acc_addr  = (state == CMD) ? cmd_addr : addr;

  assign rd_load   = !spi_csn && (((state == CMD) && last_cmd && !is_write) ||
                                  ((state == RD) && word_end));
  assign wr_commit = !spi_csn && (state == WR) && word_end;
  assign wr_ok     = wr_commit && hit && !ro;
  assign wr_drop   = wr_commit && !(hit && !ro);

  always_comb begin
    hit     = 1'b0;
    ro      = 1'b0;
    rd_word = '0;
    for (int k = 0; k < NREG; k++) begin
      if (acc_addr == AW'(k)) begin
        hit     = 1'b1;
        ro      = RO_MASK[k];
        rd_word = cfg[reg_offset(k, W) +: W];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CMD:     if (last_cmd) state_next = is_write ? WR : RD;
      WR, RD:  state_next = state;
      default: state_next = CMD;
    endcase
  end

  always_ff @(posedge spi_clk or posedge rst or posedge spi_csn) begin
    if (rst || spi_csn) state <= CMD;
    else                state <= state_next;
  end

  // Frame datapath is cleared whenever chip select is inactive, so aborted frames leave no trace.
  always_ff @(posedge spi_clk or posedge rst or posedge spi_csn) begin
    if (rst || spi_csn) begin
      bit_cnt <= '0;
      sh      <= '0;
      addr    <= '0;
      tx      <= '0;
    end else begin
      sh <= SW'({sh, spi_mosi});
      if (state == CMD) begin
        if (last_cmd) begin
          bit_cnt <= '0;
          addr    <= is_write ? cmd_addr : cmd_addr + AW'(1);
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (word_end) begin
        bit_cnt <= '0;
        addr    <= addr + AW'(1);
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (rd_load)           tx <= rd_word;
      else if (state == RD)  tx <= {tx[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      cfg <= RST_VAL;
      err <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (wr_ok && (addr == AW'(k))) cfg[reg_offset(k, W) +: W] <= word;
      end
      if (wr_drop || (rd_load && !hit)) err <= 1'b1;
    end
  end

`ifdef SPI_CFG_WSTROBE_EN
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= wr_ok;
      if (wr_ok) wr_addr <= addr;
    end
  end
`endif

  spi_miso_drv u_miso (
    .spi_clk (spi_clk),
    .rst     (rst),
    .spi_csn (spi_csn),
    .d       ((state == RD) ? tx[W-1] : 1'b0),
    .q       (spi_miso)
  );

endmodule

// File: tb/tb_spi_config_regs.sv
// Directed self-checking bench for spi_config_regs (NREG=8, W=8, AW=7, reg0 read-only).
module tb_spi_config_regs;

  localparam logic [63:0] RSTV = 64'h8877_6655_4433_225A;

  logic        spi_clk;
  logic        rst;
  logic        spi_csn;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] cfg;
  logic        err;
`ifdef SPI_CFG_WSTROBE_EN
  logic        wr_stb;
  logic [6:0]  wr_addr;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [63:0] exp_cfg;
  logic [63:0] rx;
  logic [63:0] cfg_last;

  spi_config_regs #(
    .NREG    (8),
    .W       (8),
    .AW      (7),
    .RST_VAL (RSTV),
    .RO_MASK (8'h01)
  ) dut (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .spi_csn  (spi_csn),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .cfg      (cfg),
    .err      (err)
`ifdef SPI_CFG_WSTROBE_EN
    ,
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr)
`endif
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Master drives MOSI on falling edges; MISO is captured just after the falling edge,
  // i.e. the value the master will sample on the next rising edge.
  task automatic applyStimulus(input logic [63:0] tx_vec, input int nbits,
                               output logic [63:0] rx_vec, output logic [63:0] cfg_snap);
    rx_vec   = '0;
    cfg_snap = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge spi_clk);
      spi_csn  = 1'b0;
      spi_mosi = tx_vec[63-i];
      #1;
      rx_vec[63-i] = spi_miso;
      cfg_snap     = cfg;
    end
    @(negedge spi_clk);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge spi_clk);
    rst = 1'b1;
    @(negedge spi_clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    repeat (2) @(negedge spi_clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_cfg", cfg, RSTV);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_miso", 64'(spi_miso), 64'd0);

    // Single write to reg2; cfg must not move before the last data bit
    exp_cfg = RSTV;
    applyStimulus(64'h82A5_0000_0000_0000, 16, rx, cfg_last);
    exp_cfg[2*8 +: 8] = 8'hA5;
    checkOutput("wr_no_glitch", cfg_last, RSTV);
    #1;
    checkOutput("wr_reg2", cfg, exp_cfg);
    checkOutput("wr_err", 64'(err), 64'd0);

    // Burst read from reg2: MISO quiet during command, then reg2, then reg3
    applyStimulus(64'h0200_0000_0000_0000, 24, rx, cfg_last);
    #1;
    checkOutput("rd_cmd_miso", 64'(rx[63:56]), 64'h00);
    checkOutput("rd_reg2", 64'(rx[55:48]), 64'hA5);
    checkOutput("rd_reg3", 64'(rx[47:40]), 64'h44);
    checkOutput("rd_err", 64'(err), 64'd0);
    checkOutput("idle_miso", 64'(spi_miso), 64'd0);

    // Aborted write to reg1 after 5 data bits, then a clean read of reg1
    applyStimulus(64'h81A8_0000_0000_0000, 13, rx, cfg_last);
    #1;
    checkOutput("partial_cfg", cfg, exp_cfg);
    applyStimulus(64'h0100_0000_0000_0000, 24, rx, cfg_last);
    checkOutput("after_abort_reg1", 64'(rx[55:48]), 64'h22);
    checkOutput("after_abort_reg2", 64'(rx[47:40]), 64'hA5);

    // Write to read-only reg0 is dropped and flags err
    applyStimulus(64'h80FF_0000_0000_0000, 16, rx, cfg_last);
    #1;
    checkOutput("ro_cfg", cfg, exp_cfg);
    checkOutput("ro_err", 64'(err), 64'd1);
`ifdef SPI_CFG_WSTROBE_EN
    checkOutput("ro_no_stb", 64'(wr_stb), 64'd0);
`endif

    applyStimulus(64'h843C_0000_0000_0000, 16, rx, cfg_last);
    exp_cfg[4*8 +: 8] = 8'h3C;
    #1;
    checkOutput("wr_reg4", cfg, exp_cfg);
`ifdef SPI_CFG_WSTROBE_EN
    checkOutput("stb_high", 64'(wr_stb), 64'd1);
    checkOutput("stb_addr", 64'(wr_addr), 64'd4);
    @(negedge spi_clk);
    #1;
    checkOutput("stb_low", 64'(wr_stb), 64'd0);
`endif

    pulseReset();
    checkOutput("rst2_cfg", cfg, RSTV);
    checkOutput("rst2_err", 64'(err), 64'd0);

    // Burst write running off the end of the register file
    applyStimulus(64'h8611_2233_0000_0000, 32, rx, cfg_last);
    exp_cfg = RSTV;
    exp_cfg[6*8 +: 8] = 8'h11;
    exp_cfg[7*8 +: 8] = 8'h22;
    #1;
    checkOutput("burst_cfg", cfg, exp_cfg);
    checkOutput("burst_err", 64'(err), 64'd1);

    // Read from addr 127 returns 0 with err, then wraps to reg0
    pulseReset();
    applyStimulus(64'h7F00_0000_0000_0000, 24, rx, cfg_last);
    #1;
    checkOutput("oor_rd_data", 64'(rx[55:48]), 64'h00);
    checkOutput("wrap_rd_reg0", 64'(rx[47:40]), 64'h5A);
    checkOutput("oor_rd_err", 64'(err), 64'd1);
    checkOutput("oor_rd_cfg", cfg, RSTV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
